// File: rtl/display_timings_480p.sv
// display_timings_480p: free-running raster timing generator, 640x480 @ 60 Hz
// by default. All outputs are registered and describe the same pixel.
//
// Ports:
//   clk_pix   in   pixel clock (only clock)
//   rst       in   asynchronous active-high reset
//   sx, sy    out  current horizontal / vertical position (CORDW bits)
//   hsync     out  horizontal sync, active level H_POL
//   vsync     out  vertical sync, active level V_POL
//   de        out  data enable, high inside the visible area
//   line      out  one-cycle strobe at sx == 0
//   frame     out  one-cycle strobe at sx == 0, sy == 0
//   frame_cnt out  completed frames, modulo 2**FCW
module display_timings_480p #(
   parameter int   CORDW  = 10,
   parameter int   H_RES  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_RES  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0,
   parameter int   FCW    = 16
) (
   input  logic             clk_pix,
   input  logic             rst,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line,
   output logic             frame,
   output logic [FCW-1:0]   frame_cnt
);

   localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOT - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOT - 1);
   localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
   localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
   localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

   // Next-state coordinates; every registered output is decoded from these
   // so that the strobes and syncs line up with the coordinates they follow.
   logic [CORDW-1:0] nx;
   logic [CORDW-1:0] ny;
   logic             h_wrap;
   logic             n_line;
   logic             n_frame;
   logic             n_hs;
   logic             n_vs;
   logic             n_de;
   logic             arm;

   always_comb begin
      h_wrap = (sx == H_LAST);
      nx     = sx + 1'b1;
      ny     = sy;
      if (h_wrap) begin
         nx = '0;
         if (sy == V_LAST) begin
            ny = '0;
         end else begin
            ny = sy + 1'b1;
         end
      end
      n_line  = (nx == '0);
      n_frame = n_line && (ny == '0);
      n_hs    = (nx >= HS_STA) && (nx <= HS_END);
      n_vs    = (ny >= VS_STA) && (ny <= VS_END);
      n_de    = (nx < H_ACT) && (ny < V_ACT);
   end

   // Reset parks the counters on the last pixel of the frame, so the
   // first edge after release lands exactly on the frame origin.
   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         sx        <= H_LAST;
         sy        <= V_LAST;
         hsync     <= ~H_POL;
         vsync     <= ~V_POL;
         de        <= 1'b0;
         line      <= 1'b0;
         frame     <= 1'b0;
         frame_cnt <= '0;
         arm       <= 1'b0;
      end else begin
         sx    <= nx;
         sy    <= ny;
         hsync <= n_hs ? H_POL : ~H_POL;
         vsync <= n_vs ? V_POL : ~V_POL;
         de    <= n_de;
         line  <= n_line;
         frame <= n_frame;
         // The first strobe after reset only arms the counter: a frame is
         // counted when the next one begins.
         if (n_frame) begin
            arm <= 1'b1;
            if (arm) begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_display_timings_480p.sv
// tb_display_timings_480p: checks a default 640x480 instance plus two small
// raster instances (FCW=2, and inverted sync polarity) against a model.
module tb_display_timings_480p;

   typedef struct packed {
      logic [15:0] sx;
      logic [15:0] sy;
      logic        hs;
      logic        vs;
      logic        de;
      logic        ln;
      logic        fr;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic [9:0]  d_sx, d_sy, s_sx, s_sy, p_sx, p_sy;
   logic        d_hsync, d_vsync, d_de, d_line, d_frame;
   logic        s_hsync, s_vsync, s_de, s_line, s_frame;
   logic        p_hsync, p_vsync, p_de, p_line, p_frame;
   logic [15:0] d_fc, p_fc;
   logic [1:0]  s_fc;

   display_timings_480p dut_d (
      .clk_pix(clk), .rst(rst), .sx(d_sx), .sy(d_sy),
      .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
      .line(d_line), .frame(d_frame), .frame_cnt(d_fc)
   );

   display_timings_480p #(
      .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .FCW(2)
   ) dut_s (
      .clk_pix(clk), .rst(rst), .sx(s_sx), .sy(s_sy),
      .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
      .line(s_line), .frame(s_frame), .frame_cnt(s_fc)
   );

   display_timings_480p #(
      .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_POL(1'b1), .V_POL(1'b1), .FCW(16)
   ) dut_p (
      .clk_pix(clk), .rst(rst), .sx(p_sx), .sy(p_sy),
      .hsync(p_hsync), .vsync(p_vsync), .de(p_de),
      .line(p_line), .frame(p_frame), .frame_cnt(p_fc)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   exp_t q_d[$], q_s[$], q_p[$];

   int md_x, md_y, md_a, md_f;
   int ms_x, ms_y, ms_a, ms_f;
   int mp_x, mp_y, mp_a, mp_f;

   bit mon = 1'b0;
   int fq[$], per[$], vsq[$];
   int last_cyc = 0, vs_cnt = 0, de_bad = 0, ph_cnt = 0, pv_cnt = 0;

   function automatic exp_t calc(int x, int y, int fc,
                                 int hres, int hfp, int hsy,
                                 int vres, int vfp, int vsy,
                                 bit hp, bit vp, bit r);
      exp_t e;
      bit   hw, vw;
      hw   = (x >= hres + hfp) && (x <= hres + hfp + hsy - 1);
      vw   = (y >= vres + vfp) && (y <= vres + vfp + vsy - 1);
      e.sx = 16'(x);
      e.sy = 16'(y);
      e.hs = (hw && !r) ? hp : !hp;
      e.vs = (vw && !r) ? vp : !vp;
      e.de = !r && (x < hres) && (y < vres);
      e.ln = !r && (x == 0);
      e.fr = !r && (x == 0) && (y == 0);
      e.fc = 16'(fc);
      return e;
   endfunction

   task automatic adv(inout int x, inout int y, inout int a, inout int f,
                      input int ht, input int vt, input int fmod);
      if (x == ht - 1) begin
         x = 0;
         y = (y == vt - 1) ? 0 : y + 1;
      end else begin
         x = x + 1;
      end
      if (x == 0 && y == 0) begin
         if (a != 0) f = (f + 1) % fmod;
         a = 1;
      end
   endtask

   task automatic reset_models();
      md_x = 799; md_y = 524; md_a = 0; md_f = 0;
      ms_x = 24;  ms_y = 14;  ms_a = 0; ms_f = 0;
      mp_x = 24;  mp_y = 14;  mp_a = 0; mp_f = 0;
   endtask

   task automatic push_all(bit r);
      q_d.push_back(calc(md_x, md_y, md_f, 640, 16, 96, 480, 10, 2,
                         1'b0, 1'b0, r));
      q_s.push_back(calc(ms_x, ms_y, ms_f, 16, 2, 4, 8, 2, 2,
                         1'b0, 1'b0, r));
      q_p.push_back(calc(mp_x, mp_y, mp_f, 16, 2, 4, 8, 2, 2,
                         1'b1, 1'b1, r));
   endtask

   task automatic check(string tag, exp_t o, exp_t e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s cyc=%0d obs sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d exp sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d",
                tag, cyc, o.sx, o.sy, o.hs, o.vs, o.de, o.ln, o.fr, o.fc,
                e.sx, e.sy, e.hs, e.vs, e.de, e.ln, e.fr, e.fc);
      end
   endtask

   task automatic chk(string tag, int o, int e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic cmp_all();
      exp_t o;
      if (q_d.size() == 0 || q_s.size() == 0 || q_p.size() == 0) begin
         chk("queue_empty", 0, 1);
      end else begin
         o = {16'(d_sx), 16'(d_sy), d_hsync, d_vsync, d_de, d_line,
              d_frame, d_fc};
         check("dflt", o, q_d.pop_front());
         o = {16'(s_sx), 16'(s_sy), s_hsync, s_vsync, s_de, s_line,
              s_frame, 16'(s_fc)};
         check("small", o, q_s.pop_front());
         o = {16'(p_sx), 16'(p_sy), p_hsync, p_vsync, p_de, p_line,
              p_frame, p_fc};
         check("pol", o, q_p.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin
         reset_models();
      end else begin
         adv(md_x, md_y, md_a, md_f, 800, 525, 65536);
         adv(ms_x, ms_y, ms_a, ms_f, 25, 15, 4);
         adv(mp_x, mp_y, mp_a, mp_f, 25, 15, 65536);
      end
      push_all(rst);
      @(negedge clk);
      cmp_all();
      cyc++;
      if (mon) begin
         if (s_frame) begin
            fq.push_back(int'(s_fc));
            per.push_back(cyc - last_cyc);
            vsq.push_back(vs_cnt);
            last_cyc = cyc;
            vs_cnt = 0;
         end
         if (!s_vsync) vs_cnt++;
         if (s_de && s_sy >= 8) de_bad++;
         if (fq.size() >= 1 && fq.size() < 5) begin
            if (p_hsync) ph_cnt++;
            if (p_vsync) pv_cnt++;
         end
      end
   endtask

   int n = 0, de_c = 0, hs_c = 0, hs_lo = 9999, hs_hi = -1, ln_x = 0;

   task automatic acc_line();
      n++;
      if (d_de) de_c++;
      if (!d_hsync) begin
         hs_c++;
         if (int'(d_sx) < hs_lo) hs_lo = int'(d_sx);
         if (int'(d_sx) > hs_hi) hs_hi = int'(d_sx);
      end
      if (d_line && n > 1) ln_x++;
   endtask

   initial begin
      int guard;
      int fexp[5];
      fexp = '{0, 1, 2, 3, 0};
      reset_models();

      repeat (5) tick();
      chk("rst_sx", int'(d_sx), 799);
      chk("rst_sy", int'(d_sy), 524);
      chk("rst_p_hs", int'(p_hsync), 0);
      chk("rst_p_vs", int'(p_vsync), 0);

      rst = 1'b0;
      mon = 1'b1;
      tick();
      chk("rel_sx", int'(d_sx), 0);
      chk("rel_sy", int'(d_sy), 0);
      chk("rel_frame", int'(d_frame), 1);
      chk("rel_line", int'(d_line), 1);
      chk("rel_de", int'(d_de), 1);
      chk("rel_fc", int'(d_fc), 0);
      acc_line();
      tick();
      chk("rel2_sx", int'(d_sx), 1);
      chk("rel2_frame", int'(d_frame), 0);
      chk("rel2_line", int'(d_line), 0);
      acc_line();

      guard = 0;
      while (guard < 1000) begin
         tick();
         guard++;
         if (d_line) break;
         acc_line();
      end
      chk("line_period", n, 800);
      chk("line_de_cnt", de_c, 640);
      chk("line_hs_cnt", hs_c, 96);
      chk("line_hs_lo", hs_lo, 656);
      chk("line_hs_hi", hs_hi, 751);
      chk("line_extra", ln_x, 0);
      chk("line_sy", int'(d_sy), 1);

      guard = 0;
      while (fq.size() < 5 && guard < 3000) begin
         tick();
         guard++;
      end
      chk("frame_strobes", fq.size(), 5);
      for (int k = 0; k < fq.size() && k < 5; k++) begin
         chk($sformatf("fcnt_%0d", k), fq[k], fexp[k]);
      end
      for (int k = 1; k < per.size() && k < 5; k++) begin
         chk($sformatf("fper_%0d", k), per[k], 375);
         chk($sformatf("vs_cnt_%0d", k), vsq[k], 50);
      end
      chk("de_blank", de_bad, 0);
      chk("pol_hs_cnt", ph_cnt, 240);
      chk("pol_vs_cnt", pv_cnt, 200);

      guard = 0;
      while (!(s_sx == 10'd10 && s_sy == 10'd5) && guard < 500) begin
         tick();
         guard++;
      end
      chk("mid_reach", int'(s_sx == 10'd10 && s_sy == 10'd5), 1);
      chk("mid_p_fc", int'(p_fc), 4);

      mon = 1'b0;
      #2 rst = 1'b1;
      #1;
      reset_models();
      push_all(1'b1);
      cmp_all();
      chk("async_s_sx", int'(s_sx), 24);
      chk("async_p_fc", int'(p_fc), 0);
      chk("async_d_sy", int'(d_sy), 524);

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rel_b_sx", int'(s_sx), 0);
      chk("rel_b_frame", int'(s_frame), 1);
      chk("rel_b_line", int'(s_line), 1);
      chk("rel_b_de", int'(s_de), 1);
      chk("rel_b_p_fc", int'(p_fc), 0);
      chk("rel_b_d_sx", int'(d_sx), 0);
      tick();
      chk("rel_b2_sx", int'(s_sx), 1);
      chk("rel_b2_frame", int'(s_frame), 0);
      chk("rel_b2_line", int'(s_line), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/display_timings_480p.md
DISPLAY_TIMINGS_480P -- requirements
Module: display_timings_480p

Interface
REQ-001 SHALL have parameter CORDW, default 10, screen coordinate width in bits.
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-004 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-005 SHALL have parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-006 SHALL have parameter H_POL / V_POL, default 0 / 0, active level of hsync / vsync (0 = active-low).
REQ-007 SHALL have parameter FCW, default 16, frame counter width in bits.
REQ-008 SHALL have port clk_pix  input  1  pixel clock; the only clock.
REQ-009 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have port sx  output  CORDW  horizontal position.
REQ-011 SHALL have port sy  output  CORDW  vertical position.
REQ-012 SHALL have port hsync  output  1  horizontal sync, polarity per H_POL.
REQ-013 SHALL have port vsync  output  1  vertical sync, polarity per V_POL.
REQ-014 SHALL have port de  output  1  data enable, high in the active area.
REQ-015 SHALL have port line  output  1  one-cycle strobe at the start of each line.
REQ-016 SHALL have port frame  output  1  one-cycle strobe at the start of each frame.
REQ-017 SHALL have port frame_cnt  output  FCW  count of completed frames.

Function
REQ-018 Totals: H_TOT = H_RES+H_FP+H_SYNC+H_BP (default 800); V_TOT = V_RES+V_FP+V_SYNC+V_BP (default 525).
REQ-019 sx SHALL increment by 1 every clk_pix cycle and wrap from H_TOT-1 to 0.
REQ-020 sy SHALL increment by 1 in the cycle in which sx wraps, and hold otherwise.
REQ-021 sy SHALL wrap from V_TOT-1 to 0 in the cycle in which sx wraps.
REQ-022 All outputs SHALL be registered.
REQ-023 hsync, vsync, de, line and frame SHALL describe the sx/sy values present in the same cycle, with zero relative skew (they are computed from the next-state coordinates).
REQ-024 hsync SHALL equal H_POL when H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1 (default 656..751), else !H_POL.
REQ-025 vsync SHALL equal V_POL when V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1 (default 490..491), else !V_POL; vsync is line-granular.
REQ-026 de SHALL be 1 iff sx < H_RES and sy < V_RES.
REQ-027 line SHALL be 1 iff sx == 0.
REQ-028 frame SHALL be 1 iff sx == 0 and sy == 0.
REQ-029 frame_cnt SHALL increment by 1, modulo 2^FCW, in the same cycle that frame is 1, except on the first frame after reset; it therefore reads 0 throughout the first frame.
REQ-030 An internal arm flag SHALL be cleared by reset, set on the first frame strobe, and gate the frame_cnt increment.
REQ-031 Coordinate arithmetic SHALL be CORDW bits wide; no out-of-range value (sx >= H_TOT or sy >= V_TOT) SHALL ever appear.

Reset
REQ-032 While rst=1, outputs SHALL be: sx=H_TOT-1 (799), sy=V_TOT-1 (524), hsync=!H_POL, vsync=!V_POL, de=0, line=0, frame=0, frame_cnt=0; arm SHALL be 0.
REQ-033 The first rising clk_pix edge after rst deasserts SHALL produce sx=0, sy=0, de=1, line=1, frame=1 and frame_cnt=0.
REQ-034 An asserted rst mid-frame SHALL force the REQ-032 values immediately, without waiting for a clock edge; timing SHALL restart per REQ-033.

Verification
REQ-035 Reset release: hold rst 5 cycles, then release -> first edge gives sx=0, sy=0, frame=1, line=1, de=1, frame_cnt=0; next edge gives sx=1, frame=0, line=0.
REQ-036 Horizontal timing over one line -> de high for sx 0..639; hsync low for exactly sx 656..751 (96 cycles); line high only at sx=0; line period 800 cycles.
REQ-037 Vertical timing over one frame -> vsync low for exactly sy 490..491 (1600 cycles); de=0 for all sy >= 480; frame period 420000 cycles.
REQ-038 Frame counting, FCW=2 -> frame_cnt reads 0,1,2,3,0 at the frame strobes of frames 1..5; there is no increment at the first strobe.
REQ-039 Mid-frame reset: assert rst at sx=300, sy=200 between edges -> outputs reach the REQ-032 values without a clock edge; after release, REQ-035 repeats and frame_cnt=0.
REQ-040 Polarity: H_POL=1, V_POL=1 -> hsync/vsync high only in the REQ-024/REQ-025 windows; reset values are 0.
